// File: rtl/irq148_pkg.sv
// Shared types and helpers for the 74LS148 receive decoder.
// Pure declarations: no latency, no flow control.
package irq148_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUAL    = 2'd1,
        HOLD    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [2:0] CODE_NONE = 3'b111;
    localparam logic [7:0] Y_OFF     = 8'hFF;

    function automatic logic [7:0] decode_onehot_n(input logic [2:0] code);
        return ~(8'd1 << code);
    endfunction

endpackage

// File: rtl/sync_bus.sv
// Multi-bit flop-chain synchroniser; latency STAGES edges, no flow control.
// Every bit is treated independently, so callers must qualify multi-bit codes for stability.
module sync_bus #(
    parameter int               WIDTH     = 5,
    parameter int               STAGES    = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] bus,
    output logic [WIDTH-1:0] synced
);

    logic [WIDTH-1:0] chain [STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                chain[i] <= RESET_VAL;
            end
        end else begin
            chain[0] <= bus;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign synced = chain[STAGES-1];

endmodule

// File: rtl/irq_decode_148rx.sv
// Receive side of a 74LS148 encoder: synchronise, qualify, decode to active-low one-hot.
// VALID rises SYNC_STAGES+STABLE_CYCLES edges after a pin change; result held until ACK.
module irq_decode_148rx
    import irq148_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       A2,
    input  logic       A1,
    input  logic       A0,
    input  logic       GS,
    input  logic       EO,
    input  logic       EN,
    input  logic       ACK,
    output logic [7:0] Y,
    output logic [2:0] IDX,
    output logic       VALID,
    output logic       ERR
);

    localparam int             CW       = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_CYCLES);
    localparam logic [4:0]     PIN_IDLE = {CODE_NONE, 2'b11};

    logic [4:0] synced;
    logic [2:0] s_code;
    logic       s_gs;
    logic       s_eo;
    logic       illegal;
    logic       req;

    sync_bus #(
        .WIDTH     (5),
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (PIN_IDLE)
    ) u_sync (
        .clk    (clk),
        .rst    (rst),
        .bus    ({A2, A1, A0, GS, EO}),
        .synced (synced)
    );

    assign s_code  = ~synced[4:2];
    assign s_gs    = synced[1];
    assign s_eo    = synced[0];
    // A contradictory GS/EO pair or a code without GS is demoted to "no request".
    assign illegal = (!s_gs && !s_eo) || (s_gs && (s_code != 3'd0));
    assign req     = !s_gs && !illegal;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    logic [2:0]    code_q, code_n;
    logic [7:0]    y_q, y_n;
    logic [2:0]    idx_q, idx_n;
    logic          valid_q, valid_n;
    logic          err_q, err_n;
    logic          fire;
    logic [2:0]    fire_code;

    assign cnt_inc = cnt + CW'(1);

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        code_n    = code_q;
        y_n       = y_q;
        idx_n     = idx_q;
        valid_n   = valid_q;
        err_n     = err_q | illegal;
        fire      = 1'b0;
        fire_code = s_code;

        unique case (state)
            IDLE: begin
                if (EN && req) begin
                    code_n = s_code;
                    cnt_n  = CW'(1);
                    if (STABLE_CYCLES == 1) fire = 1'b1;
                    else                    state_n = QUAL;
                end
            end
            QUAL: begin
                if (!EN || !req) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (s_code != code_q) begin
                    code_n = s_code;
                    cnt_n  = CW'(1);
                end else if (cnt_inc == CNT_LAST) begin
                    fire      = 1'b1;
                    fire_code = code_q;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            HOLD: begin
                if (ACK) begin
                    valid_n = 1'b0;
                    y_n     = Y_OFF;
                    state_n = RELEASE;
                end
            end
            RELEASE: begin
                // The acknowledged code must go away or change before it can re-trigger.
                if (!req) begin
                    state_n = IDLE;
                end else if (EN && (s_code != code_q)) begin
                    code_n = s_code;
                    cnt_n  = CW'(1);
                    if (STABLE_CYCLES == 1) fire = 1'b1;
                    else                    state_n = QUAL;
                end
            end
            default: state_n = IDLE;
        endcase

        if (fire) begin
            state_n = HOLD;
            cnt_n   = '0;
            valid_n = 1'b1;
            idx_n   = fire_code;
            y_n     = decode_onehot_n(fire_code);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            code_q  <= '0;
            y_q     <= Y_OFF;
            idx_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            code_q  <= code_n;
            y_q     <= y_n;
            idx_q   <= idx_n;
            valid_q <= valid_n;
            err_q   <= err_n;
        end
    end

    assign Y     = y_q;
    assign IDX   = idx_q;
    assign VALID = valid_q;
    assign ERR   = err_q;

endmodule

// File: tb/tb_irq_decode_148rx.sv
// Directed plus random stimulus for irq_decode_148rx, checked against a run-length reference model.
module tb_irq_decode_148rx;

    localparam int SS = 2;
    localparam int SC = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       A2 = 1'b1, A1 = 1'b1, A0 = 1'b1, GS = 1'b1, EO = 1'b0;
    logic       EN = 1'b1;
    logic       ACK = 1'b0;
    logic [7:0] Y;
    logic [2:0] IDX;
    logic       VALID;
    logic       ERR;

    int total = 0;
    int bad   = 0;

    irq_decode_148rx #(
        .SYNC_STAGES   (SS),
        .STABLE_CYCLES (SC)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .A2    (A2),
        .A1    (A1),
        .A0    (A0),
        .GS    (GS),
        .EO    (EO),
        .EN    (EN),
        .ACK   (ACK),
        .Y     (Y),
        .IDX   (IDX),
        .VALID (VALID),
        .ERR   (ERR)
    );

    always #5 clk = ~clk;

    // Reference model: pins seen SS edges late; a request fires after SC consecutive
    // enabled, legal, identical codes; after ACK the same code is blocked until it changes.
    logic [4:0] hist [SS];
    bit         m_hold, m_rel, m_valid, m_err;
    logic [2:0] m_acked, m_runcode, m_idx;
    int         m_run;
    logic [7:0] m_y;

    task automatic model_edge();
        logic [4:0] v;
        logic [2:0] c;
        bit         ill, rq;
        if (rst) begin
            for (int i = 0; i < SS; i++) hist[i] = 5'b11111;
            m_hold = 0; m_rel = 0; m_valid = 0; m_err = 0;
            m_acked = 0; m_runcode = 0; m_idx = 0; m_run = 0; m_y = 8'hFF;
            return;
        end
        v = hist[SS-1];
        for (int i = SS - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = {A2, A1, A0, GS, EO};
        c   = ~v[4:2];
        ill = (!v[1] && !v[0]) || (v[1] && c != 3'd0);
        if (ill) m_err = 1;
        rq  = !v[1] && !ill;
        if (m_hold) begin
            if (ACK) begin
                m_hold = 0; m_valid = 0; m_y = 8'hFF; m_rel = 1; m_acked = m_idx;
            end
        end else if (!rq) begin
            m_run = 0; m_rel = 0;
        end else if (!EN) begin
            m_run = 0;
        end else if (!(m_rel && c == m_acked)) begin
            if (m_run > 0 && c == m_runcode) m_run++;
            else begin m_runcode = c; m_run = 1; end
            m_rel = 0;
            if (m_run >= SC) begin
                m_hold = 1; m_valid = 1; m_idx = c; m_y = ~(8'd1 << c); m_run = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("Y", Y, m_y);
        chk("IDX", {5'd0, IDX}, {5'd0, m_idx});
        chk("VALID", {7'd0, VALID}, {7'd0, m_valid});
        chk("ERR", {7'd0, ERR}, {7'd0, m_err});
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pins_idle();
        {A2, A1, A0} = 3'b111; GS = 1'b1; EO = 1'b0;
    endtask

    task automatic pins_req(input logic [2:0] a);
        {A2, A1, A0} = a; GS = 1'b0; EO = 1'b1;
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        steps(2);
        chk("rst_y", Y, 8'hFF);
        chk("rst_valid", {7'd0, VALID}, 8'd0);
        chk("rst_idx", {5'd0, IDX}, 8'd0);
        chk("rst_err", {7'd0, ERR}, 8'd0);
        rst = 1'b0;
        pins_idle(); EN = 1'b1;
        steps(20);
        chk("idle_valid", {7'd0, VALID}, 8'd0);

        // Single request, code 5
        pins_req(3'b010);
        steps(3);
        chk("req_early", {7'd0, VALID}, 8'd0);
        step();
        chk("req_valid", {7'd0, VALID}, 8'd1);
        chk("req_idx", {5'd0, IDX}, 8'd5);
        chk("req_y", Y, 8'b1101_1111);
        ACK = 1'b1; step(); ACK = 1'b0;
        chk("ack_valid", {7'd0, VALID}, 8'd0);
        chk("ack_y", Y, 8'hFF);
        steps(10);
        chk("no_retrig", {7'd0, VALID}, 8'd0);

        // Priority upgrade to I7 from RELEASE
        pins_req(3'b000);
        steps(4);
        chk("up_valid", {7'd0, VALID}, 8'd1);
        chk("up_idx", {5'd0, IDX}, 8'd7);
        chk("up_y", Y, 8'b0111_1111);
        ACK = 1'b1; step(); ACK = 1'b0;

        // Glitch rejection
        for (int i = 0; i < 10; i++) begin
            pins_req((i % 2 == 0) ? 3'b010 : 3'b011);
            step();
        end
        chk("glitch_valid", {7'd0, VALID}, 8'd0);
        pins_req(3'b011);
        steps(4);
        chk("glitch_hold_valid", {7'd0, VALID}, 8'd1);
        chk("glitch_hold_idx", {5'd0, IDX}, 8'd4);
        ACK = 1'b1; step(); ACK = 1'b0;
        pins_idle(); steps(4);

        // Illegal GS=0 with EO=0
        {A2, A1, A0} = 3'b111; GS = 1'b0; EO = 1'b0;
        step();
        pins_idle();
        steps(2);
        chk("ill_err", {7'd0, ERR}, 8'd1);
        steps(5);
        chk("ill_sticky", {7'd0, ERR}, 8'd1);
        chk("ill_valid", {7'd0, VALID}, 8'd0);

        // Abort in QUAL via EN=0
        pins_req(3'b100);
        steps(3);
        EN = 1'b0;
        steps(5);
        chk("abort_valid", {7'd0, VALID}, 8'd0);
        pins_idle(); EN = 1'b1;
        steps(3);

        // Reset while holding
        pins_req(3'b110);
        steps(4);
        chk("hold_valid", {7'd0, VALID}, 8'd1);
        rst = 1'b1; step(); rst = 1'b0;
        chk("hrst_valid", {7'd0, VALID}, 8'd0);
        chk("hrst_y", Y, 8'hFF);
        chk("hrst_idx", {5'd0, IDX}, 8'd0);
        chk("hrst_err", {7'd0, ERR}, 8'd0);
        pins_idle(); steps(3);

        // Random traffic
        for (int seg = 0; seg < 150; seg++) begin
            int kind;
            int len;
            kind = $urandom_range(0, 9);
            if (kind < 3)       pins_idle();
            else if (kind < 9)  pins_req(3'($urandom_range(0, 7)));
            else                {A2, A1, A0, GS, EO} = 5'($urandom_range(0, 31));
            len = $urandom_range(1, 6);
            for (int k = 0; k < len; k++) begin
                EN  = ($urandom_range(0, 9) != 0);
                ACK = ($urandom_range(0, 2) == 0);
                rst = ($urandom_range(0, 99) == 0);
                step();
            end
        end
        rst = 1'b0; ACK = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/irq_decode_148rx.md
Name: irq_decode_148rx

Overview:
- Receive side of a 74LS148-style priority-encoder interface.
- Synchronises the encoder's active-low outputs (A2..A0, GS, EO) into the clock domain and qualifies them for stability.
- Decodes the accepted code back to an active-low one-hot vector, 74LS138 style, plus a binary index.
- Holds the result under a VALID/ACK handshake so an interrupt-service controller can consume one request at a time.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the input synchroniser (>=2).
- STABLE_CYCLES, 2, consecutive identical synchronised samples required before a code is accepted (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- A2  in  1  encoder output bit 2, active-low.
- A1  in  1  encoder output bit 1, active-low.
- A0  in  1  encoder output bit 0, active-low.
- GS  in  1  encoder group-select, active-low (request present).
- EO  in  1  encoder enable-out, active-low (enabled, no input active).
- EN  in  1  capture enable, active-high.
- ACK  in  1  consumer acknowledge, active-high, sampled in HOLD only.
- Y  out  8  decoded request, active-low one-hot; Y[i]=0 for accepted index i.
- IDX  out  3  accepted index, true binary = ~{A2,A1,A0}.
- VALID  out  1  request held, awaiting ACK.
- ERR  out  1  sticky illegal-input flag.

Behaviour:
- Reset values:
  - Y=8'hFF, IDX=0, VALID=0, ERR=0, state=IDLE, qualify counter=0.
  - All synchroniser flops load 1 (inactive).
- Synchroniser output: s_code=~{A2,A1,A0}, s_gs, s_eo. They are valid SYNC_STAGES edges after a pin change.
- Illegal samples:
  - An illegal sample is s_gs=0 with s_eo=0, or s_gs=1 with s_code!=0.
  - An illegal sample sets ERR=1 on the next edge. ERR clears only on rst.
  - That cycle is treated as "no request" (s_gs taken as 1).
- States: IDLE, QUAL, HOLD, RELEASE.
- IDLE:
  - If EN=1 and s_gs=0 (legal): latch s_code, counter=1, go to QUAL.
  - If STABLE_CYCLES=1, go directly to HOLD instead.
- QUAL:
  - EN=0 or s_gs=1: go to IDLE.
  - s_code differs from the latched code: relatch, counter=1.
  - Otherwise counter++. When it reaches STABLE_CYCLES: go to HOLD and, on the same edge, drive VALID=1, IDX=latched code, Y=~(1<<code).
- Latency: VALID rises at rising edge number SYNC_STAGES+STABLE_CYCLES, counting the first edge that samples a new pin value (4 with defaults).
- HOLD:
  - VALID, IDX and Y are frozen. EN and input changes are ignored.
  - ACK=1: on the next edge VALID=0, Y=8'hFF, IDX retained, go to RELEASE.
- ACK outside HOLD is ignored. ACK coincident with VALID rising is not seen until the following cycle.
- RELEASE (no retrigger of the acked code):
  - s_gs=1: go to IDLE.
  - s_gs=0, EN=1 and s_code!=acked code: latch, counter=1, go to QUAL.
  - Same code held: stay in RELEASE.
- Simultaneous events:
  - rst has priority over everything.
  - In QUAL, EN=0 beats a code change.
  - An illegal sample in HOLD sets ERR but does not drop VALID.
- Reset mid-operation (any state, including HOLD with VALID=1) returns all outputs to their reset values on that edge.
- Y and IDX are registered outputs. No combinational path from any input to any output.

Decomposition:
- Package irq148_pkg holds:
  - state enum {IDLE, QUAL, HOLD, RELEASE};
  - constant CODE_NONE=3'b111 (active-low idle code);
  - constant Y_OFF=8'hFF;
  - a decode function code->active-low one-hot.
- One sub-module, sync_bus (params WIDTH, STAGES, RESET_VAL), instantiated once with WIDTH=5 for A2..A0, GS, EO.

Test Plan:
- Reset: assert rst 2 cycles -> Y=8'hFF, VALID=0, IDX=0, ERR=0; then hold A=111, GS=1, EO=0, EN=1 for 20 cycles -> VALID stays 0.
- Single request: A=3'b010, GS=0, EO=1 from edge 0 -> VALID=1 after edge 4, IDX=5, Y=8'b11011111. ACK one cycle -> next edge VALID=0, Y=8'hFF. Inputs held 10 more cycles -> no re-assert.
- Priority upgrade: from RELEASE with code 5 held, change A to 3'b000 (I7) -> VALID=1 four edges later with IDX=7, Y=8'b01111111.
- Glitch rejection: A alternates 3'b010/3'b011 every cycle with GS=0 for 10 cycles -> VALID stays 0. Then hold 3'b011 -> VALID after 4 edges, IDX=4.
- Illegal input: GS=0 with EO=0 for one cycle -> ERR=1 from the edge after the synchroniser delay; VALID stays 0. ERR stays 1 until rst.
- Abort and reset: EN=0 during QUAL -> IDLE, no VALID. Separately, rst in HOLD (VALID=1) -> next edge VALID=0, Y=8'hFF, IDX=0.
